// File: rtl/jtag_tap_responder.sv
// ---------------------------------------------------------------------------
// jtag_tap_responder
//   Target-side IEEE 1149.1 TAP controller running entirely on clk. The JTAG
//   pins (tck/tms/tdi/trstn) are oversampled through synchronizers, and tck
//   edges are recovered by edge detection, so no second clock domain exists.
//   Supports IDCODE, BYPASS and one USER data register. A USER Update-DR is
//   handed to the SoC as a 1-clk strobe.
//
//   Optional build macro: JTAG_TAP_STATUS_EN
//     Adds opcode 'h9 STATUS with an 8-bit sticky status DR:
//     {4'b0, sticky_bad_ir, sticky_trst_seen, sticky_update_seen, 1'b1},
//     write-1-to-clear on Update-DR. Without it 'h9 is plain BYPASS.
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   tck_i           JTAG clock (async, oversampled; must be <= clk/6)
//   trstn_i         JTAG reset, active-low (async, synchronized)
//   tms_i, tdi_i    JTAG mode select / data in
//   tdo_o, tdo_oe_o JTAG data out and its enable (1 only in Shift-DR/IR)
//   user_capture_i  value captured into USER DR at Capture-DR
//   user_data_o     last USER value committed at Update-DR
//   user_update_o   1-clk strobe when user_data_o is written
//   tap_state_o     current TAP state (1149.1 encoding)
//   ir_o            current instruction
// ---------------------------------------------------------------------------
module jtag_tap_responder #(
  parameter logic [31:0] IDCODE_VAL  = 32'h249511C3,
  parameter int          IR_WIDTH    = 4,
  parameter int          USER_WIDTH  = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tck_i,
  input  logic                  trstn_i,
  input  logic                  tms_i,
  input  logic                  tdi_i,
  output logic                  tdo_o,
  output logic                  tdo_oe_o,
  input  logic [USER_WIDTH-1:0] user_capture_i,
  output logic [USER_WIDTH-1:0] user_data_o,
  output logic                  user_update_o,
  output logic [3:0]            tap_state_o,
  output logic [IR_WIDTH-1:0]   ir_o
);

  localparam int DR_W = (USER_WIDTH > 32) ? USER_WIDTH : 32;

  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(8);
  localparam logic [IR_WIDTH-1:0] OP_STATUS = IR_WIDTH'(9);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  // ---------------------------------------------------------------------
  // Pin synchronizers and tck edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_tck_sync;
  logic [SYNC_STAGES-1:0] r_tms_sync;
  logic [SYNC_STAGES-1:0] r_tdi_sync;
  logic [SYNC_STAGES-1:0] r_trstn_sync;
  logic                   r_tck_prev;
  logic                   r_trstn_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_sync   <= '0;
      r_tms_sync   <= '0;
      r_tdi_sync   <= '0;
      r_trstn_sync <= '1;
      r_tck_prev   <= 1'b0;
      r_trstn_prev <= 1'b1;
    end else begin
      r_tck_sync   <= {r_tck_sync[SYNC_STAGES-2:0], tck_i};
      r_tms_sync   <= {r_tms_sync[SYNC_STAGES-2:0], tms_i};
      r_tdi_sync   <= {r_tdi_sync[SYNC_STAGES-2:0], tdi_i};
      r_trstn_sync <= {r_trstn_sync[SYNC_STAGES-2:0], trstn_i};
      r_tck_prev   <= r_tck_sync[SYNC_STAGES-1];
      r_trstn_prev <= r_trstn_sync[SYNC_STAGES-1];
    end
  end

  logic w_tck_s, w_tms_s, w_tdi_s, w_trstn_s;
  logic w_tck_rise, w_tck_fall, w_trst_hold, w_adv;

  assign w_tck_s    = r_tck_sync[SYNC_STAGES-1];
  assign w_tms_s    = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi_s    = r_tdi_sync[SYNC_STAGES-1];
  assign w_trstn_s  = r_trstn_sync[SYNC_STAGES-1];
  assign w_tck_rise = w_tck_s & ~r_tck_prev;
  assign w_tck_fall = ~w_tck_s & r_tck_prev;
  // Held in TLR while trstn is low and also on the clk where it releases,
  // so a tck rise coinciding with trstn release cannot move the TAP.
  assign w_trst_hold = ~w_trstn_s | ~r_trstn_prev;
  assign w_adv       = w_tck_rise & ~w_trst_hold;

  // ---------------------------------------------------------------------
  // TAP state machine
  // ---------------------------------------------------------------------
  tap_state_t r_state, w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= TLR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_trst_hold) begin
      w_next = TLR;
    end else if (w_tck_rise) begin
      case (r_state)
        TLR:      w_next = w_tms_s ? TLR      : RTI;
        RTI:      w_next = w_tms_s ? SEL_DR   : RTI;
        SEL_DR:   w_next = w_tms_s ? SEL_IR   : CAP_DR;
        CAP_DR:   w_next = w_tms_s ? EX1_DR   : SH_DR;
        SH_DR:    w_next = w_tms_s ? EX1_DR   : SH_DR;
        EX1_DR:   w_next = w_tms_s ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: w_next = w_tms_s ? EX2_DR   : PAUSE_DR;
        EX2_DR:   w_next = w_tms_s ? UPD_DR   : SH_DR;
        UPD_DR:   w_next = w_tms_s ? SEL_DR   : RTI;
        SEL_IR:   w_next = w_tms_s ? TLR      : CAP_IR;
        CAP_IR:   w_next = w_tms_s ? EX1_IR   : SH_IR;
        SH_IR:    w_next = w_tms_s ? EX1_IR   : SH_IR;
        EX1_IR:   w_next = w_tms_s ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: w_next = w_tms_s ? EX2_IR   : PAUSE_IR;
        EX2_IR:   w_next = w_tms_s ? UPD_IR   : SH_IR;
        UPD_IR:   w_next = w_tms_s ? SEL_DR   : RTI;
        default:  w_next = TLR;
      endcase
    end
  end

  logic w_enter_upd_ir, w_enter_upd_dr;
  assign w_enter_upd_ir = w_adv & (w_next == UPD_IR);
  assign w_enter_upd_dr = w_adv & (w_next == UPD_DR);

  // ---------------------------------------------------------------------
  // Instruction register and decode
  // ---------------------------------------------------------------------
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_ir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_sr <= '0;
      r_ir    <= OP_IDCODE;
    end else begin
      if (w_adv && r_state == CAP_IR)
        r_ir_sr <= IR_WIDTH'(2'b01);
      else if (w_adv && r_state == SH_IR)
        r_ir_sr <= {w_tdi_s, r_ir_sr[IR_WIDTH-1:1]};

      if (r_state == TLR || w_trst_hold)
        r_ir <= OP_IDCODE;
      else if (w_enter_upd_ir)
        r_ir <= r_ir_sr;
    end
  end

  logic w_sel_idcode, w_sel_user, w_sel_status;
  assign w_sel_idcode = (r_ir == OP_IDCODE);
  assign w_sel_user   = (r_ir == OP_USER);
`ifdef JTAG_TAP_STATUS_EN
  assign w_sel_status = (r_ir == OP_STATUS);
`else
  assign w_sel_status = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Shared data register: all DRs time-share r_dr, the selected length
  // decides where tdi enters. Bits above that length are don't-care.
  // ---------------------------------------------------------------------
  logic [DR_W-1:0] r_dr;
  logic [DR_W-1:0] w_dr_capture;
  logic [DR_W-1:0] w_dr_sr1;
  logic [DR_W-1:0] w_dr_shift;
  int              w_dr_len;

`ifdef JTAG_TAP_STATUS_EN
  logic r_sticky_bad_ir, r_sticky_trst, r_sticky_upd;
`endif

  always_comb begin
    w_dr_len = 1;
    if (w_sel_idcode)      w_dr_len = 32;
    else if (w_sel_user)   w_dr_len = USER_WIDTH;
    else if (w_sel_status) w_dr_len = 8;
  end

  always_comb begin
    w_dr_capture = '0;
    if (w_sel_idcode)
      w_dr_capture[31:0] = IDCODE_VAL;
    else if (w_sel_user)
      w_dr_capture[USER_WIDTH-1:0] = user_capture_i;
`ifdef JTAG_TAP_STATUS_EN
    else if (w_sel_status)
      w_dr_capture[7:0] = {4'b0000, r_sticky_bad_ir, r_sticky_trst, r_sticky_upd, 1'b1};
`endif
  end

  assign w_dr_sr1 = r_dr >> 1;

  // Right shift within the selected length; continuing past the length
  // just recirculates, so the last N bits shifted in are always retained.
  always_comb begin
    w_dr_shift = '0;
    for (int i = 0; i < DR_W; i++) begin
      if (i == w_dr_len - 1)
        w_dr_shift[i] = w_tdi_s;
      else if (i < w_dr_len - 1)
        w_dr_shift[i] = w_dr_sr1[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dr <= '0;
    end else if (w_adv) begin
      if (r_state == CAP_DR)     r_dr <= w_dr_capture;
      else if (r_state == SH_DR) r_dr <= w_dr_shift;
    end
  end

  // ---------------------------------------------------------------------
  // tdo launched on tck fall
  // ---------------------------------------------------------------------
  logic r_tdo, r_tdo_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else if (w_trst_hold) begin
      r_tdo_oe <= 1'b0;
    end else if (w_tck_fall) begin
      r_tdo_oe <= (r_state == SH_IR) || (r_state == SH_DR);
      if (r_state == SH_IR)      r_tdo <= r_ir_sr[0];
      else if (r_state == SH_DR) r_tdo <= r_dr[0];
    end
  end

  // ---------------------------------------------------------------------
  // USER commit; only rst clears the committed value
  // ---------------------------------------------------------------------
  logic [USER_WIDTH-1:0] r_user_data;
  logic                  r_user_update;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_user_data   <= '0;
      r_user_update <= 1'b0;
    end else begin
      r_user_update <= 1'b0;
      if (w_enter_upd_dr && w_sel_user) begin
        r_user_data   <= r_dr[USER_WIDTH-1:0];
        r_user_update <= 1'b1;
      end
    end
  end

`ifdef JTAG_TAP_STATUS_EN
  logic w_ir_defined, w_set_bad, w_clr;
  assign w_ir_defined = (r_ir_sr == OP_IDCODE) || (r_ir_sr == OP_USER) ||
                        (r_ir_sr == OP_STATUS) || (r_ir_sr == OP_BYPASS);
  assign w_set_bad    = w_enter_upd_ir & ~w_ir_defined;
  assign w_clr        = w_enter_upd_dr & w_sel_status;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky_bad_ir <= 1'b0;
      r_sticky_trst   <= 1'b0;
      r_sticky_upd    <= 1'b0;
    end else begin
      r_sticky_bad_ir <= (r_sticky_bad_ir & ~(w_clr & r_dr[3])) | w_set_bad;
      r_sticky_trst   <= (r_sticky_trst   & ~(w_clr & r_dr[2])) | ~w_trstn_s;
      r_sticky_upd    <= (r_sticky_upd    & ~(w_clr & r_dr[1])) | r_user_update;
    end
  end
`endif

  assign tdo_o         = r_tdo;
  assign tdo_oe_o      = r_tdo_oe;
  assign user_data_o   = r_user_data;
  assign user_update_o = r_user_update;
  assign tap_state_o   = r_state;
  assign ir_o          = r_ir;

endmodule

// File: tb/tb_jtag_tap_responder.sv
module tb_jtag_tap_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        tck_i, trstn_i, tms_i, tdi_i;
  logic        tdo_o, tdo_oe_o;
  logic [31:0] user_capture_i;
  logic [31:0] user_data_o;
  logic        user_update_o;
  logic [3:0]  tap_state_o;
  logic [3:0]  ir_o;

  jtag_tap_responder dut (
    .clk            (clk),
    .rst            (rst),
    .tck_i          (tck_i),
    .trstn_i        (trstn_i),
    .tms_i          (tms_i),
    .tdi_i          (tdi_i),
    .tdo_o          (tdo_o),
    .tdo_oe_o       (tdo_oe_o),
    .user_capture_i (user_capture_i),
    .user_data_o    (user_data_o),
    .user_update_o  (user_update_o),
    .tap_state_o    (tap_state_o),
    .ir_o           (ir_o)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  bit    q_exp[$];
  string cur_tag     = "none";

  int upd_pulses  = 0;
  int upd_run     = 0;
  int upd_max_run = 0;

  always @(negedge clk) begin
    if (user_update_o === 1'b1) begin
      upd_run = upd_run + 1;
      if (upd_run == 1) upd_pulses = upd_pulses + 1;
      if (upd_run > upd_max_run) upd_max_run = upd_run;
    end else begin
      upd_run = 0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tck period (10 clks). tdo is sampled just before the rising edge and
  // compared against the scoreboard when an expectation is pending.
  task automatic tck_pulse(input bit tms, input bit tdi);
    tms_i = tms;
    tdi_i = tdi;
    wait_clks(5);
    if (q_exp.size() > 0) begin
      bit e;
      e = q_exp.pop_front();
      check({cur_tag, "_tdo"}, tdo_o, e);
      check({cur_tag, "_oe"}, tdo_oe_o, 1);
    end
    tck_i = 1'b1;
    wait_clks(5);
    tck_i = 1'b0;
  endtask

  // From RTI: load IR, return to RTI. Capture pattern 0001 is expected on tdo.
  task automatic scan_ir(input logic [3:0] v);
    logic [3:0] cap;
    cap = 4'b0001;
    tck_pulse(1, 0);
    tck_pulse(1, 0);
    tck_pulse(0, 0);
    tck_pulse(0, 0);
    for (int i = 0; i < 4; i++) q_exp.push_back(cap[i]);
    for (int i = 0; i < 4; i++) tck_pulse(i == 3, v[i]);
    tck_pulse(1, 0);
    tck_pulse(0, 0);
  endtask

  // From RTI: scan len DR bits, Update-DR, return to RTI.
  task automatic scan_dr(input logic [63:0] din, input int len, input logic [63:0] exp_out);
    tck_pulse(1, 0);
    tck_pulse(0, 0);
    tck_pulse(0, 0);
    for (int i = 0; i < len; i++) q_exp.push_back(exp_out[i]);
    for (int i = 0; i < len; i++) tck_pulse(i == len - 1, din[i]);
    tck_pulse(1, 0);
    tck_pulse(0, 0);
  endtask

  int p0;

  initial begin
    rst            = 1'b1;
    tck_i          = 1'b0;
    trstn_i        = 1'b1;
    tms_i          = 1'b1;
    tdi_i          = 1'b0;
    user_capture_i = 32'h0;
    wait_clks(4);

    check("rst_state", tap_state_o, 4'hF);
    check("rst_ir", ir_o, 4'h1);
    check("rst_tdo", tdo_o, 0);
    check("rst_oe", tdo_oe_o, 0);
    check("rst_udata", user_data_o, 0);
    check("rst_upd", user_update_o, 0);

    rst = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 5; i++) tck_pulse(1, 0);
    check("tlr_hold", tap_state_o, 4'hF);
    tck_pulse(0, 0);
    check("rti", tap_state_o, 4'hC);

    cur_tag = "idcode";
    scan_dr(64'h0, 32, 64'h249511C3);
    check("idcode_ir", ir_o, 4'h1);

    cur_tag = "ircap";
    scan_ir(4'hF);
    check("ir_bypass", ir_o, 4'hF);

    cur_tag = "bypass";
    scan_dr(64'hD, 4, 64'hA);

    cur_tag = "user";
    user_capture_i = 32'h12345678;
    scan_ir(4'h8);
    check("ir_user", ir_o, 4'h8);
    p0 = upd_pulses;
    scan_dr(64'hDEADBEEF, 32, 64'h12345678);
    check("user_data", user_data_o, 32'hDEADBEEF);
    check("user_pulses", upd_pulses - p0, 1);
    check("user_pulse_width", upd_max_run, 1);

    cur_tag = "overlong";
    user_capture_i = 32'hCAFEBABE;
    scan_dr(64'h5A0F1E2D3C, 40, {24'h0, 8'h3C, 32'hCAFEBABE});
    check("overlong_data", user_data_o, 32'h5A0F1E2D);
    check("overlong_pulses", upd_pulses - p0, 2);

    cur_tag = "trst_scan";
    tck_pulse(1, 0);
    tck_pulse(0, 0);
    tck_pulse(0, 0);
    q_exp.push_back(1'b0);
    q_exp.push_back(1'b1);
    q_exp.push_back(1'b1);
    for (int i = 0; i < 3; i++) tck_pulse(0, 1);
    check("trst_in_shdr", tap_state_o, 4'h2);
    trstn_i = 1'b0;
    wait_clks(6);
    check("trst_state", tap_state_o, 4'hF);
    check("trst_ir", ir_o, 4'h1);
    trstn_i = 1'b1;
    wait_clks(6);
    check("trst_udata", user_data_o, 32'h5A0F1E2D);
    check("trst_pulses", upd_pulses - p0, 2);
    check("trst_state_after", tap_state_o, 4'hF);
    tck_pulse(0, 0);

    cur_tag = "rawir";
    scan_ir(4'h3);
    check("ir_raw3", ir_o, 4'h3);
    scan_ir(4'h9);
    check("ir_raw9", ir_o, 4'h9);
`ifdef JTAG_TAP_STATUS_EN
    cur_tag = "status";
    scan_dr(64'h08, 8, 64'h0F);
    scan_dr(64'h00, 8, 64'h07);
`else
    cur_tag = "op9_bypass";
    scan_dr(64'h3, 2, 64'h2);
`endif

    cur_tag = "rst_scan";
    scan_ir(4'h8);
    p0 = upd_pulses;
    tck_pulse(1, 0);
    tck_pulse(0, 0);
    tck_pulse(0, 0);
    q_exp.push_back(1'b0);
    q_exp.push_back(1'b1);
    tck_pulse(0, 1);
    tck_pulse(0, 1);
    tck_i = 1'b1;
    wait_clks(2);
    rst = 1'b1;
    wait_clks(1);
    check("rstmid_state", tap_state_o, 4'hF);
    check("rstmid_ir", ir_o, 4'h1);
    check("rstmid_tdo", tdo_o, 0);
    check("rstmid_oe", tdo_oe_o, 0);
    check("rstmid_udata", user_data_o, 0);
    check("rstmid_upd", user_update_o, 0);
    tck_i = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(4);
    check("rstmid_pulses", upd_pulses - p0, 0);
    check("rstmid_state_after", tap_state_o, 4'hF);

    cur_tag = "tms5";
    tck_pulse(0, 0);
    scan_ir(4'h8);
    scan_dr(64'h0BADF00D, 32, 64'hCAFEBABE);
    check("tms5_udata_pre", user_data_o, 32'h0BADF00D);
    tck_pulse(1, 0);
    for (int i = 0; i < 5; i++) tck_pulse(1, 0);
    check("tms5_state", tap_state_o, 4'hF);
    check("tms5_ir", ir_o, 4'h1);
    check("tms5_udata", user_data_o, 32'h0BADF00D);
    check("scoreboard_drained", q_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
